// File: rtl/act_lut_interp_pkg.sv
// Shared constants for the activation LUT interpolator.
//   ADDR_W : LUT address width (table depth = 2**ADDR_W)
//   FRAC_W : fractional input bits used for interpolation
//   DATA_W : LUT entry / result width (unsigned)
//   PROD_W : width of the signed diff*frac product
package act_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = DATA_W + FRAC_W + 2;

endpackage

// File: rtl/act_lut_interp_if.sv
// Sample/result stream bundle for act_lut_interp.
//   in_valid/in_ready/in_x    : sample stream into the block
//   out_valid/out_ready/out_y : interpolated result stream out of the block
// slave = the interpolator, master = the producer/consumer side.
interface act_lut_interp_if #(
  parameter int unsigned ADDR_W = act_pkg::ADDR_W,
  parameter int unsigned FRAC_W = act_pkg::FRAC_W,
  parameter int unsigned DATA_W = act_pkg::DATA_W
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [ADDR_W+FRAC_W-1:0]   in_x;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_y;

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y
  );

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y
  );

endinterface

// File: rtl/act_interp_dp.sv
// Combinational interpolation datapath.
//   base_i : LUT[addr]
//   next_i : LUT[addr+1]
//   frac_i : fractional position between base and next
//   y_o    : base + floor((next-base)*frac / 2**FRAC_W), clamped to [0, 2**DATA_W-1]
module act_interp_dp #(
  parameter int unsigned DATA_W = act_pkg::DATA_W,
  parameter int unsigned FRAC_W = act_pkg::FRAC_W
) (
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] next_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int unsigned PW = DATA_W + FRAC_W + 2;
  localparam logic signed [PW-1:0] YMAX = {{(PW-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic signed [DATA_W:0] diff;
  logic signed [FRAC_W:0] frac_s;
  logic signed [PW-1:0]   diff_x;
  logic signed [PW-1:0]   frac_x;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   step;
  logic signed [PW-1:0]   sum;

  always_comb begin
    diff   = $signed({1'b0, next_i}) - $signed({1'b0, base_i});
    frac_s = $signed({1'b0, frac_i});
    diff_x = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
    frac_x = {{(PW-FRAC_W-1){1'b0}}, frac_s};
    prod   = diff_x * frac_x;
    // Arithmetic shift floors toward -inf for descending segments.
    step   = prod >>> FRAC_W;
    sum    = $signed({{(PW-DATA_W){1'b0}}, base_i}) + step;
    if (sum[PW-1]) begin
      y_o = '0;
    end else if (sum > YMAX) begin
      y_o = '1;
    end else begin
      y_o = sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/act_lut_interp.sv
// Activation LUT reader with linear interpolation, two-stage pipeline.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : sample/result streams (act_lut_interp_if.slave)
//   lut_addr   : registered address to the external LUT
//   lut_base   : LUT[lut_addr]
//   lut_next   : LUT[lut_addr+1] (LUT[last] at the top address)
// S0 registers address/fraction on accept; S1 samples the LUT pair and
// registers the interpolated result. Latency 2, 1 sample/cycle sustained.
module act_lut_interp #(
  parameter int unsigned ADDR_W = act_pkg::ADDR_W,
  parameter int unsigned FRAC_W = act_pkg::FRAC_W,
  parameter int unsigned DATA_W = act_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  act_lut_interp_if.slave    bus,
  output logic [ADDR_W-1:0]  lut_addr,
  input  logic [DATA_W-1:0]  lut_base,
  input  logic [DATA_W-1:0]  lut_next
);

  logic              s0_valid_q, s0_valid_d;
  logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_y_q, out_y_d;

  logic              advance;
  logic              accept;
  logic [DATA_W-1:0] y_interp;

  act_interp_dp #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_dp (
    .base_i (lut_base),
    .next_i (lut_next),
    .frac_i (frac_q),
    .y_o    (y_interp)
  );

  always_comb begin
    advance      = !out_valid_q || bus.out_ready;
    bus.in_ready = !s0_valid_q || advance;
    accept       = bus.in_valid && bus.in_ready;

    s0_valid_d  = s0_valid_q;
    lut_addr_d  = lut_addr_q;
    frac_d      = frac_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;

    if (advance) begin
      out_valid_d = s0_valid_q;
      if (s0_valid_q) begin
        out_y_d = y_interp;
      end
    end

    // S0 empties when its sample moves to S1, unless refilled this cycle.
    if (accept) begin
      s0_valid_d = 1'b1;
      lut_addr_d = bus.in_x[ADDR_W+FRAC_W-1 -: ADDR_W];
      frac_d     = bus.in_x[FRAC_W-1:0];
    end else if (advance) begin
      s0_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      lut_addr_q  <= '0;
      frac_q      <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      lut_addr_q  <= lut_addr_d;
      frac_q      <= frac_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

  assign lut_addr      = lut_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;

endmodule

// File: tb/tb_act_lut_interp.sv
module tb_act_lut_interp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] lut_addr;
  logic [7:0] lut_base;
  logic [7:0] lut_next;
  logic [7:0] lut [16];

  int unsigned checks = 0;
  int unsigned errors = 0;

  act_lut_interp_if bus ();

  act_lut_interp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .lut_addr (lut_addr),
    .lut_base (lut_base),
    .lut_next (lut_next)
  );

  always #5 clk = ~clk;

  assign lut_base = lut[lut_addr];
  assign lut_next = lut[(lut_addr == 4'hF) ? 4'hF : lut_addr + 4'd1];

  function automatic int model(int x);
    int a, f, b, n, d, q, y;
    a = x / 16;
    f = x % 16;
    b = int'(lut[a]);
    n = int'(lut[(a == 15) ? 15 : a + 1]);
    d = (n - b) * f;
    q = (d >= 0) ? d / 16 : -((-d + 15) / 16);
    y = b + q;
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    return y;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Send one sample with out_ready=1, wait (bounded) for its result.
  task automatic run_one(input string tag, input logic [7:0] x, input int exp,
                         input bit chk_lat);
    int n;
    bit got;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_x      = x;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 1;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    check({tag, "_valid"}, int'(got), 1);
    check(tag, int'(bus.out_y), exp);
    if (chk_lat) check({tag, "_latency"}, n, 2);
    @(posedge clk);
  endtask

  initial begin
    int q[$];
    int nres, cyc, idx, vcount;
    int bp_exp [3];

    for (int i = 0; i < 16; i++) lut[i] = 8'd15;
    lut[0] = 8'd0;
    lut[1] = 8'd12;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b0;

    // 1: reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_y", int'(bus.out_y), 0);
    check("rst_lut_addr", int'(lut_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_in_ready", int'(bus.in_ready), 1);

    // 2/3: directed singles
    run_one("x08", 8'h08, 6, 1'b1);
    run_one("x00", 8'h00, 0, 1'b0);
    run_one("x1C", 8'h1C, 14, 1'b0);
    run_one("x14", 8'h14, 12, 1'b0);
    run_one("xF7_top", 8'hF7, 15, 1'b0);

    // 3: back-to-back stream 0x00..0xFF
    nres = 0;
    cyc = 0;
    for (int i = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (q.size() > 0) check("stream", int'(bus.out_y), q.pop_front());
        else check("stream_extra", 1, 0);
        nres++;
      end
      if (i < 256) begin
        bus.in_valid = 1'b1;
        bus.in_x     = 8'(i);
        if (bus.in_ready) begin
          q.push_back(model(i));
          i++;
        end
      end else begin
        bus.in_valid = 1'b0;
        if (q.size() == 0) break;
      end
      @(posedge clk);
    end
    check("stream_count", nres, 256);
    check("stream_rate", int'(cyc <= 259), 1);

    // 4: backpressure
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 8'h08;
    @(posedge clk);
    @(negedge clk);
    bus.in_x = 8'h1C;
    @(posedge clk);
    @(negedge clk);
    bus.in_x = 8'h30;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", int'(bus.out_valid), 1);
      check("bp_hold_y", int'(bus.out_y), 6);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_addr_hold", int'(lut_addr), 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bp_exp[0] = 6;
    bp_exp[1] = 14;
    bp_exp[2] = 15;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        if (idx < 3) check("bp_order", int'(bus.out_y), bp_exp[idx]);
        else check("bp_extra", 1, 0);
        idx++;
      end
      @(negedge clk);
    end
    check("bp_count", idx, 3);

    // 5: descending segment and clamp
    lut[3] = 8'd200;
    lut[4] = 8'd100;
    run_one("desc_x38", 8'h38, 150, 1'b0);
    lut[0] = 8'd255;
    lut[1] = 8'd255;
    run_one("clamp_x0F", 8'h0F, 255, 1'b0);

    // 6: async reset with two samples in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 8'h38;
    @(posedge clk);
    @(negedge clk);
    bus.in_x = 8'h1C;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("fl_pre_valid", int'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("fl_rst_valid", int'(bus.out_valid), 0);
    check("fl_rst_addr", int'(lut_addr), 0);
    check("fl_rst_y", int'(bus.out_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    check("fl_no_output", vcount, 0);
    check("fl_in_ready", int'(bus.in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
